// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter
//  Purpose  : Shares one single-port unified instruction/data memory between
//             the fetch stage (I port) and the MEM stage (D port). Each access
//             is issued as a one-cycle mem_en strobe, then a fixed MEM_LAT
//             wait, then a one-cycle DONE where read data is returned.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                  clock; asynchronous active-low reset
//    if_req/if_addr            fetch request (level) and byte address
//    if_rdata/if_done/if_stall fetch result, completion pulse, stall
//    d_req/d_we/d_addr/
//    d_wdata/d_be              load/store request
//    d_rdata/d_done/d_stall    load result, completion pulse, stall
//    mem_en/mem_we/mem_addr/
//    mem_wdata/mem_be          registered memory command
//    mem_rdata                 memory read data, valid MEM_LAT after mem_en
// ============================================================================
module imem_dmem_arbiter #(
    parameter int XLEN    = 32,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_done,
    output logic            d_stall,
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            store_q, store_d;      // current access is a store
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic            grant_d, grant_i;      // start an access next cycle
    logic            done_w;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        store_d     = store_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        grant_d     = 1'b0;
        grant_i     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_req) begin
                    grant_d = 1'b1;
                end else if (if_req) begin
                    grant_i = 1'b1;
                end
            end
            ST_ISSUE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Only the other port may be granted here; this is what
                // forces strict alternation under continuous contention.
                state_d = ST_IDLE;
                if (owner_q == OWN_D && if_req) begin
                    grant_i = 1'b1;
                end else if (owner_q == OWN_I && d_req) begin
                    grant_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_d) begin
            state_d     = ST_ISSUE;
            owner_d     = OWN_D;
            cnt_d       = CNT_LOAD;
            store_d     = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_we ? d_be : 4'hF;
        end else if (grant_i) begin
            state_d     = ST_ISSUE;
            owner_d     = OWN_I;
            cnt_d       = CNT_LOAD;
            store_d     = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = 4'hF;
        end

        // Every entry into ISSUE goes through a grant, so the strobes are
        // simply the registered grant.
        mem_en_d = grant_d | grant_i;
        mem_we_d = grant_d & d_we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_D;
            cnt_q       <= 4'd0;
            store_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            store_q     <= store_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign done_w   = (state_q == ST_DONE);
    assign if_done  = done_w & (owner_q == OWN_I);
    assign d_done   = done_w & (owner_q == OWN_D);
    assign if_rdata = if_done ? mem_rdata : '0;
    assign d_rdata  = (d_done & ~store_q) ? mem_rdata : '0;
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_dmem_arbiter
//  Purpose  : Self-checking bench for imem_dmem_arbiter. Directed scenarios
//             on a MEM_LAT=2 instance (A) and a MEM_LAT=1 instance (B),
//             then randomized traffic on A against a transaction-timing model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    localparam int XLEN  = 32;
    localparam int A_LAT = 2;
    localparam int B_LAT = 1;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // instance A (MEM_LAT = 2)
    logic a_if_req, a_if_done, a_if_stall, a_d_req, a_d_we, a_d_done, a_d_stall;
    logic a_mem_en, a_mem_we;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_d_be, a_mem_be;

    // instance B (MEM_LAT = 1)
    logic b_if_req, b_if_done, b_if_stall, b_d_req, b_d_we, b_d_done, b_d_stall;
    logic b_mem_en, b_mem_we;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_d_be, b_mem_be;

    imem_dmem_arbiter #(.XLEN(XLEN), .MEM_LAT(A_LAT)) u_dut_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata),
        .if_done(a_if_done), .if_stall(a_if_stall),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_be(a_d_be), .d_rdata(a_d_rdata), .d_done(a_d_done), .d_stall(a_d_stall),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_rdata(a_mem_rdata)
    );

    imem_dmem_arbiter #(.XLEN(XLEN), .MEM_LAT(B_LAT)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
        .if_done(b_if_done), .if_stall(b_if_stall),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_be(b_d_be), .d_rdata(b_d_rdata), .d_done(b_d_done), .d_stall(b_d_stall),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(b_mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Moves to 1 time unit after the next rising edge: start of a new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference model state for the random phase: one access in flight at
    // most, described by the cycles of its strobe and its completion.
    bit          m_busy;
    bit          m_own_d;
    int          m_issue, m_done;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] i_ret, d_ret;

    task automatic grant(input bit to_d, input int cyc);
        m_busy  = 1'b1;
        m_own_d = to_d;
        m_issue = cyc + 1;
        m_done  = cyc + 1 + A_LAT;
        if (to_d) begin
            e_addr  = a_d_addr;
            e_we    = a_d_we;
            e_wdata = a_d_wdata;
            e_be    = a_d_we ? a_d_be : 4'hF;
            e_rdata = d_ret;
        end else begin
            e_addr  = a_if_addr;
            e_we    = 1'b0;
            e_wdata = 32'h0;
            e_be    = 4'hF;
            e_rdata = i_ret;
        end
    endtask

    initial begin
        bit i_done_prev, d_done_prev, exp_en, exp_di, exp_dd;
        int prev_own, pct;

        rst = 1'b0;
        a_if_req = 0; a_if_addr = 0; a_d_req = 0; a_d_we = 0; a_d_addr = 0;
        a_d_wdata = 0; a_d_be = 0; a_mem_rdata = JUNK;
        b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0;
        b_d_wdata = 0; b_d_be = 0; b_mem_rdata = JUNK;
        tick(); tick();
        chk1 ("rst_mem_en",    a_mem_en,    1'b0);
        chk1 ("rst_mem_we",    a_mem_we,    1'b0);
        chk32("rst_mem_addr",  a_mem_addr,  32'h0);
        chk32("rst_mem_wdata", a_mem_wdata, 32'h0);
        chk32("rst_mem_be",    32'(a_mem_be), 32'h0);
        chk1 ("rst_if_done",   a_if_done,   1'b0);
        chk1 ("rst_d_done",    a_d_done,    1'b0);
        chk32("rst_d_rdata",   a_d_rdata,   32'h0);
        rst = 1'b1;
        tick();

        // ---- single fetch ------------------------------------------------
        a_if_req = 1; a_if_addr = 32'h100;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            a_mem_rdata = (c == 3) ? 32'h0050_0093 : JUNK;
            if (c == 4) a_if_req = 0;
            settle();
            chk1 ("fetch_en",    a_mem_en, c == 1);
            if (c == 1) begin
                chk32("fetch_addr", a_mem_addr, 32'h100);
                chk1 ("fetch_we",   a_mem_we, 1'b0);
                chk32("fetch_be",   32'(a_mem_be), 32'hF);
            end
            chk1 ("fetch_done",  a_if_done, c == 3);
            chk32("fetch_rdata", a_if_rdata, (c == 3) ? 32'h0050_0093 : 32'h0);
            chk1 ("fetch_stall", a_if_stall, c <= 2);
            chk1 ("fetch_ddone", a_d_done, 1'b0);
        end

        // ---- simultaneous requests: D wins, then I -----------------------
        tick();
        a_if_req = 1; a_if_addr = 32'h104;
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h2000; a_d_wdata = 32'h1111; a_d_be = 4'h0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            a_mem_rdata = (c == 3) ? 32'hCAFE_0001 : (c == 6) ? 32'h00A0_0113 : JUNK;
            if (c == 4) a_d_req = 0;
            if (c == 7) a_if_req = 0;
            settle();
            chk1("sim_en", a_mem_en, (c == 1) || (c == 4));
            if (c == 1) chk32("sim_addr_d", a_mem_addr, 32'h2000);
            if (c == 4) chk32("sim_addr_i", a_mem_addr, 32'h104);
            chk1 ("sim_d_done",   a_d_done,  c == 3);
            chk1 ("sim_if_done",  a_if_done, c == 6);
            chk32("sim_d_rdata",  a_d_rdata,  (c == 3) ? 32'hCAFE_0001 : 32'h0);
            chk32("sim_if_rdata", a_if_rdata, (c == 6) ? 32'h00A0_0113 : 32'h0);
            chk1 ("sim_if_stall", a_if_stall, c <= 5);
            chk1 ("sim_d_stall",  a_d_stall,  c <= 2);
        end

        // ---- store -------------------------------------------------------
        tick();
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h2004; a_d_wdata = 32'hDEAD_BEEF; a_d_be = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            if (c == 4) begin a_d_req = 0; a_d_we = 0; end
            a_mem_rdata = JUNK;
            settle();
            chk1("st_en", a_mem_en, c == 1);
            chk1("st_we", a_mem_we, c == 1);
            if (c == 1 || c == 2) begin
                chk32("st_addr",  a_mem_addr,  32'h2004);
                chk32("st_wdata", a_mem_wdata, 32'hDEAD_BEEF);
                chk32("st_be",    32'(a_mem_be), 32'h3);
            end
            chk1 ("st_done",  a_d_done, c == 3);
            chk32("st_rdata", a_d_rdata, 32'h0);
        end

        // ---- reset mid-WAIT of a D access --------------------------------
        tick();
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h3000;
        tick();
        chk1("rw_issue_en", a_mem_en, 1'b1);
        tick();
        rst = 1'b0; a_d_req = 0;
        settle();
        chk1 ("rw_mem_en",   a_mem_en,   1'b0);
        chk32("rw_mem_addr", a_mem_addr, 32'h0);
        chk1 ("rw_d_done",   a_d_done,   1'b0);
        chk1 ("rw_if_done",  a_if_done,  1'b0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk1("rw_idle_en",   a_mem_en, 1'b0);
            chk1("rw_idle_done", a_d_done, 1'b0);
        end

        // ---- reset during the DONE cycle drops the pulse immediately ----
        a_d_req = 1; a_d_addr = 32'h3004;
        tick(); tick(); tick();
        a_mem_rdata = 32'h1234_5678;
        settle();
        chk1("rd_done_before", a_d_done, 1'b1);
        rst = 1'b0; a_d_req = 0;
        settle();
        chk1 ("rd_done_after",  a_d_done,  1'b0);
        chk32("rd_rdata_after", a_d_rdata, 32'h0);
        tick();
        rst = 1'b1; a_mem_rdata = JUNK;
        tick();

        // ---- MEM_LAT = 1 instance: single load --------------------------
        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h40;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            b_mem_rdata = (c == 2) ? 32'h0BAD_F00D : JUNK;
            if (c == 3) b_d_req = 0;
            settle();
            chk1 ("lat1_en",    b_mem_en, c == 1);
            if (c == 1) chk32("lat1_addr", b_mem_addr, 32'h40);
            chk1 ("lat1_done",  b_d_done, c == 2);
            chk32("lat1_rdata", b_d_rdata, (c == 2) ? 32'h0BAD_F00D : 32'h0);
            chk1 ("lat1_stall", b_d_stall, c <= 1);
        end

        // ---- randomized traffic on A ------------------------------------
        // First 60 cycles: both ports request continuously (grants must
        // alternate). Afterwards: sparse random requests.
        tick();
        m_busy = 0; i_done_prev = 0; d_done_prev = 0; prev_own = -1;
        for (int cyc = 0; cyc < 460; cyc++) begin
            if (cyc > 0) tick();
            pct = (cyc < 60) ? 100 : 40;
            if (!a_if_req || i_done_prev) begin
                a_if_req = ($urandom_range(99) < pct);
                a_if_addr = {16'h0000, 14'($urandom), 2'b00};
                i_ret = $urandom;
            end
            if (!a_d_req || d_done_prev) begin
                a_d_req   = ($urandom_range(99) < pct);
                a_d_we    = $urandom_range(1) == 1;
                a_d_addr  = {1'b1, 31'($urandom)};
                a_d_wdata = $urandom;
                a_d_be    = 4'($urandom);
                d_ret     = $urandom;
            end
            exp_en = m_busy && (cyc == m_issue);
            exp_dd = m_busy && (cyc == m_done) && m_own_d;
            exp_di = m_busy && (cyc == m_done) && !m_own_d;
            a_mem_rdata = (m_busy && cyc == m_done) ? e_rdata : $urandom;
            settle();

            chk1("rnd_en", a_mem_en, exp_en);
            chk1("rnd_we", a_mem_we, exp_en && e_we);
            if (exp_en) begin
                chk32("rnd_addr", a_mem_addr, e_addr);
                chk32("rnd_be",   32'(a_mem_be), 32'(e_be));
                if (e_we) chk32("rnd_wdata", a_mem_wdata, e_wdata);
            end
            chk1 ("rnd_if_done",  a_if_done, exp_di);
            chk1 ("rnd_d_done",   a_d_done,  exp_dd);
            chk32("rnd_if_rdata", a_if_rdata, exp_di ? e_rdata : 32'h0);
            chk32("rnd_d_rdata",  a_d_rdata,  (exp_dd && !e_we) ? e_rdata : 32'h0);
            chk1 ("rnd_if_stall", a_if_stall, a_if_req && !exp_di);
            chk1 ("rnd_d_stall",  a_d_stall,  a_d_req && !exp_dd);

            // Under full contention, the owner of consecutive strobes
            // (D addresses have bit 31 set) must alternate.
            if (cyc < 60 && a_mem_en) begin
                if (prev_own >= 0) chk1("cont_alternate", a_mem_addr[31], prev_own == 0);
                prev_own = a_mem_addr[31] ? 1 : 0;
            end

            i_done_prev = exp_di;
            d_done_prev = exp_dd;
            if (m_busy && cyc == m_done) begin
                m_busy = 0;
                if (m_own_d && a_if_req)       grant(1'b0, cyc);
                else if (!m_own_d && a_d_req)  grant(1'b1, cyc);
            end else if (!m_busy) begin
                if (a_d_req)       grant(1'b1, cyc);
                else if (a_if_req) grant(1'b0, cyc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
